// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART core.
// FSM encodings, default oversampling and the parity function.
package uart_pkg;

  localparam int OS_DEFAULT = 16;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  // Data is zero-extended to 9 bits; padding does not change the XOR.
  function automatic logic parity(
    input logic [8:0] data,
    input logic       odd
  );
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// First-word fall-through FIFO used for both UART directions.
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_core.sv
// Full-duplex UART: TX FIFO and serializer, oversampling RX and RX FIFO.
// Shared baud tick; config is latched per frame in each direction.
module uart_core
  import uart_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int TX_DEPTH    = 8,
  parameter int RX_DEPTH    = 8,
  parameter int OS          = OS_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       brd,
  input  logic              cfg_par_en,
  input  logic              cfg_par_odd,
  input  logic              cfg_two_stop,
  input  logic              cfg_loopback,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic              err_clr,
  output logic              err_frame,
  output logic              err_parity,
  output logic              err_overrun,
  output logic              tx_busy,
  input  logic              rxd,
  output logic              txd
);

  localparam int CW = $clog2(OS);
  localparam logic [CW-1:0] OS_LAST   = CW'(OS - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(OS / 2 - 1);
  localparam logic [3:0]    DLAST     = 4'(DATA_W - 1);

  logic [15:0] baud_cnt;
  logic        tick;

  assign tick = (baud_cnt >= brd);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       baud_cnt <= '0;
    else if (tick) baud_cnt <= '0;
    else           baud_cnt <= baud_cnt + 16'd1;
  end

  logic              tx_full;
  logic              tx_empty;
  logic [DATA_W-1:0] tx_dout;
  logic              tx_pop;
  tx_state_e         tx_state;
  logic [CW-1:0]     tx_cnt;
  logic [3:0]        tx_bit;
  logic [DATA_W-1:0] tx_sh;
  logic              tx_par_en;
  logic              tx_parb;
  logic              tx_stop2;
  logic              tx_stopn;
  logic              txd_int;
  logic              tx_last;

  assign tx_ready = !tx_full;
  assign tx_busy  = (tx_state != TX_IDLE) || !tx_empty;
  assign txd      = cfg_loopback ? 1'b1 : txd_int;
  assign tx_last  = tick && (tx_cnt == OS_LAST);

  // Pop either from idle or straight out of the final stop bit.
  assign tx_pop = tick && !tx_empty &&
                  ((tx_state == TX_IDLE) ||
                   ((tx_state == TX_STOP) && tx_last &&
                    (tx_stopn == tx_stop2)));

  uart_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_valid && !tx_full),
    .din   (tx_data),
    .pop   (tx_pop),
    .full  (tx_full),
    .empty (tx_empty),
    .dout  (tx_dout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state  <= TX_IDLE;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_sh     <= '0;
      tx_par_en <= 1'b0;
      tx_parb   <= 1'b0;
      tx_stop2  <= 1'b0;
      tx_stopn  <= 1'b0;
      txd_int   <= 1'b1;
    end else if (tx_pop) begin
      tx_state  <= TX_START;
      tx_cnt    <= '0;
      tx_sh     <= tx_dout;
      tx_parb   <= parity(9'(tx_dout), cfg_par_odd);
      tx_par_en <= cfg_par_en;
      tx_stop2  <= cfg_two_stop;
      txd_int   <= 1'b0;
    end else if (tick && tx_state != TX_IDLE) begin
      if (tx_cnt != OS_LAST) begin
        tx_cnt <= tx_cnt + 1'b1;
      end else begin
        tx_cnt <= '0;
        case (tx_state)
          TX_START: begin
            txd_int  <= tx_sh[0];
            tx_sh    <= tx_sh >> 1;
            tx_bit   <= '0;
            tx_state <= TX_DATA;
          end
          TX_DATA: begin
            if (tx_bit != DLAST) begin
              txd_int <= tx_sh[0];
              tx_sh   <= tx_sh >> 1;
              tx_bit  <= tx_bit + 1'b1;
            end else if (tx_par_en) begin
              txd_int  <= tx_parb;
              tx_state <= TX_PARITY;
            end else begin
              txd_int  <= 1'b1;
              tx_stopn <= 1'b0;
              tx_state <= TX_STOP;
            end
          end
          TX_PARITY: begin
            txd_int  <= 1'b1;
            tx_stopn <= 1'b0;
            tx_state <= TX_STOP;
          end
          TX_STOP: begin
            if (tx_stopn != tx_stop2) tx_stopn <= 1'b1;
            else                      tx_state <= TX_IDLE;
          end
          default: tx_state <= TX_IDLE;
        endcase
      end
    end
  end

  logic [SYNC_STAGES-1:0] sync;
  logic                   rx_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= '1;
    else     sync <= {sync[SYNC_STAGES-2:0], rxd};
  end

  assign rx_in = cfg_loopback ? txd_int : sync[SYNC_STAGES-1];

  rx_state_e         rx_state;
  logic [CW-1:0]     rx_cnt;
  logic [3:0]        rx_bit;
  logic [DATA_W-1:0] rx_sh;
  logic              rx_par_en;
  logic              rx_par_odd;
  logic              rx_parb;
  logic              rx_push;
  logic              rx_full;
  logic              rx_empty;
  logic              rx_last;
  logic              frame_evt;
  logic              par_evt;
  logic              ovr_evt;

  assign rx_last   = tick && (rx_cnt == OS_LAST);
  assign rx_push   = rx_last && (rx_state == RX_STOP);
  assign frame_evt = rx_push && !rx_in;
  assign par_evt   = rx_push && rx_par_en &&
                     (rx_parb != parity(9'(rx_sh), rx_par_odd));
  assign ovr_evt   = rx_push && rx_full && !rx_ready;
  assign rx_valid  = !rx_empty;

  uart_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .din   (rx_sh),
    .pop   (rx_ready),
    .full  (rx_full),
    .empty (rx_empty),
    .dout  (rx_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_sh      <= '0;
      rx_par_en  <= 1'b0;
      rx_par_odd <= 1'b0;
      rx_parb    <= 1'b0;
    end else if (tick) begin
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (!rx_in) rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_cnt != HALF_LAST) begin
            rx_cnt <= rx_cnt + 1'b1;
          end else if (rx_in) begin
            rx_state <= RX_IDLE;
          end else begin
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_par_en  <= cfg_par_en;
            rx_par_odd <= cfg_par_odd;
            rx_state   <= RX_DATA;
          end
        end
        RX_DATA: begin
          if (rx_cnt != OS_LAST) begin
            rx_cnt <= rx_cnt + 1'b1;
          end else begin
            rx_cnt <= '0;
            rx_sh  <= {rx_in, rx_sh[DATA_W-1:1]};
            rx_bit <= rx_bit + 1'b1;
            if (rx_bit == DLAST)
              rx_state <= rx_par_en ? RX_PARITY : RX_STOP;
          end
        end
        RX_PARITY: begin
          if (rx_cnt != OS_LAST) begin
            rx_cnt <= rx_cnt + 1'b1;
          end else begin
            rx_cnt   <= '0;
            rx_parb  <= rx_in;
            rx_state <= RX_STOP;
          end
        end
        RX_STOP: begin
          // Leave mid stop bit so the next start edge is caught early.
          if (rx_cnt != OS_LAST) rx_cnt <= rx_cnt + 1'b1;
          else                   rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_frame   <= 1'b0;
      err_parity  <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      err_frame   <= (err_frame   && !err_clr) || frame_evt;
      err_parity  <= (err_parity  && !err_clr) || par_evt;
      err_overrun <= (err_overrun && !err_clr) || ovr_evt;
    end
  end

endmodule
